// File: rtl/bcd_a_binario_if.sv
// Handshake/data bundle between the decimal entry logic and the BCD-to-binary decoder.
interface bcd_a_binario_if;
    logic        valid;
    logic [20:0] codigo_BCD;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output valid, codigo_BCD,
        input  bin, busy, done, error
    );

    modport slave (
        input  valid, codigo_BCD,
        output bin, busy, done, error
    );
endinterface

// File: rtl/bcd_a_binario.sv
// Sequential signed 5-digit BCD to 16-bit two's-complement decoder (reverse double-dabble).
module bcd_a_binario (
    input  logic               CLK100MHZ,
    input  logic               reset,
    bcd_a_binario_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t      state;
    logic        sign;
    logic        digit_err;
    logic [19:0] digits;
    logic [19:0] acc;
    logic [4:0]  cnt;
    logic [15:0] bin_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;

    logic [39:0] shifted;
    logic        nibble_bad;
    logic        out_of_range;

    // One reverse double-dabble step: shift right, then correct each digit nibble >= 8 by -3.
    always_comb begin
        shifted = {digits, acc} >> 1;
        for (int unsigned i = 0; i < 5; i++) begin
            if (shifted[20 + 4*i +: 4] >= 4'd8)
                shifted[20 + 4*i +: 4] = shifted[20 + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        nibble_bad = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bus.codigo_BCD[4*i +: 4] > 4'd9)
                nibble_bad = 1'b1;
        end
    end

    assign out_of_range = sign ? (acc > 20'd32768) : (acc > 20'd32767);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state     <= IDLE;
            sign      <= 1'b0;
            digit_err <= 1'b0;
            digits    <= '0;
            acc       <= '0;
            cnt       <= '0;
            bin_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.valid) begin
                        sign      <= bus.codigo_BCD[20];
                        digits    <= bus.codigo_BCD[19:0];
                        acc       <= '0;
                        cnt       <= '0;
                        digit_err <= nibble_bad;
                        busy_r    <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {digits, acc} <= shifted;
                    cnt           <= cnt + 5'd1;
                    if (cnt == 5'd19)
                        state <= FINISH;
                end
                FINISH: begin
                    if (digit_err || out_of_range) begin
                        bin_r   <= '0;
                        error_r <= 1'b1;
                    end else begin
                        bin_r   <= sign ? (16'd0 - acc[15:0]) : acc[15:0];
                        error_r <= 1'b0;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bin   = bin_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.error = error_r;
endmodule

// File: tb/tb_bcd_a_binario.sv
// Directed and randomized checks of bcd_a_binario against a decimal arithmetic reference.
module tb_bcd_a_binario;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    bcd_a_binario_if bus ();

    bcd_a_binario dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the decimal number directly, then apply the range rules.
    function automatic void model(input logic [20:0] code, output logic [15:0] b, output logic e);
        int   m;
        logic de;
        logic [3:0] d;
        m  = 0;
        de = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            d = code[4*k +: 4];
            if (d > 4'd9) de = 1'b1;
            m = m * 10 + int'(d);
        end
        if (de || (!code[20] && m > 32767) || (code[20] && m > 32768)) begin
            b = 16'h0000;
            e = 1'b1;
        end else begin
            b = code[20] ? 16'(-m) : 16'(m);
            e = 1'b0;
        end
    endfunction

    // Issue one request and wait (bounded) for done; checks latency, busy span and done width.
    task automatic convert(input string tag, input logic [20:0] code,
                           input logic [15:0] exp_bin, input logic exp_err);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        bus.valid      = 1'b1;
        bus.codigo_BCD = code;
        @(posedge clk); #1;
        bus.valid      = 1'b0;
        bus.codigo_BCD = 21'($urandom);
        busy_cnt = bus.busy ? 1 : 0;
        cycles   = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk({tag, "_latency"}, 32'(cycles), 32'd21);
        chk({tag, "_busy_span"}, 32'(busy_cnt), 32'd21);
        chk({tag, "_bin"}, 32'(bus.bin), 32'(exp_bin));
        chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [15:0] mb;
        logic        me;
        logic [20:0] code;
        int          dones;
        int          cycles;

        total = 0;
        bad   = 0;
        bus.valid      = 1'b0;
        bus.codigo_BCD = '0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bin", 32'(bus.bin), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_error", 32'(bus.error), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        convert("p12345", 21'h012345, 16'h3039, 1'b0);
        convert("n12345", 21'h112345, 16'hCFC7, 1'b0);
        convert("n32768", 21'h132768, 16'h8000, 1'b0);
        convert("neg0",   21'h100000, 16'h0000, 1'b0);
        convert("p32768", 21'h032768, 16'h0000, 1'b1);
        convert("p99999", 21'h099999, 16'h0000, 1'b1);
        convert("p32767", 21'h032767, 16'h7FFF, 1'b0);
        convert("illegal", 21'h01A345, 16'h0000, 1'b1);
        convert("clr_err", 21'h000321, 16'h0141, 1'b0);

        // Second valid mid-conversion must be ignored.
        @(negedge clk);
        bus.valid = 1'b1;
        bus.codigo_BCD = 21'h000007;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.valid = 1'b1;
        bus.codigo_BCD = 21'h000009;
        @(negedge clk);
        bus.valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dones++;
                chk("ignore_latency", 32'(i), 32'd16);
            end
        end
        chk("ignore_done_count", 32'(dones), 32'd1);
        chk("ignore_bin", 32'(bus.bin), 32'h0007);

        // Reset in the middle of a conversion.
        convert("pre_rst", 21'h001234, 16'h04D2, 1'b0);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.codigo_BCD = 21'h000555;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_bin", 32'(bus.bin), 32'h0);
        chk("midrst_error", 32'(bus.error), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        // valid coincident with reset is dropped.
        @(negedge clk);
        reset = 1'b1;
        bus.valid = 1'b1;
        bus.codigo_BCD = 21'h000011;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        bus.valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid_busy", 32'(bus.busy), 32'h0);
        cycles = 0;
        dones  = 0;
        while (cycles < 25) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.done === 1'b1) dones++;
        end
        chk("rst_valid_no_done", 32'(dones), 32'd0);

        convert("p42", 21'h000042, 16'h002A, 1'b0);

        // Randomized conversions against the arithmetic reference.
        for (int n = 0; n < 40; n++) begin
            code[20] = 1'($urandom);
            code[19:16] = 4'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++)
                code[4*k +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0)
                code[4*$urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
            model(code, mb, me);
            convert($sformatf("rnd%0d", n), code, mb, me);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_a_binario.md
# bcd_a_binario

Sequential BCD-to-binary decoder, the inverse of the multiplier's binary-to-BCD stage. It takes a signed 5-digit BCD word in the same `{signo, digits}` format the display path uses and produces a 16-bit two's-complement value. It uses the reverse double-dabble algorithm, one shift per clock. It sits between the decimal entry logic and the `multiplicacion` operand inputs, so operands can be entered in decimal.

## Interface
Parameters: none (widths fixed by the 5-digit BCD format and 16-bit datapath).

Ports:
- `CLK100MHZ`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  start strobe; sampled only in IDLE.
- `codigo_BCD`  in  21  bit 20 = sign (1 = negative); bits 19:0 = five BCD digits, bits 19:16 most significant.
- `bin`  out  16  two's-complement result; held until the next completion.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bin`/`error` update.
- `error`  out  1  set with `done` if any digit is > 9 or the value is out of range; held until the next completion.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On `valid`=1, latch sign, load the 20-bit digit register from `codigo_BCD[19:0]`, clear the 20-bit binary accumulator, clear the iteration counter.
  - Set `digit_err` if any nibble > 9.
  - Set `busy`=1 and go to SHIFT.
- SHIFT, once per cycle:
  - Shift `{digits, acc}` right by 1 as one 40-bit register; the digit LSB enters the acc MSB.
  - Then, for each of the 5 digit nibbles, subtract 3 if the nibble is ≥ 8.
  - Increment the counter. After the 20th shift, go to FINISH.
- FINISH: magnitude M = acc, 17 significant bits, max 99999.
  - Error if `digit_err`, or sign=0 and M > 32767, or sign=1 and M > 32768. On error: `bin`=0, `error`=1.
  - Otherwise: `bin` = sign ? −M : M, using 16-bit two's complement; `error`=0.
  - Negative zero yields `bin`=0 with no error.
  - Pulse `done`, clear `busy`, return to IDLE.
- `valid` during SHIFT or FINISH is ignored; it is not queued.
- `codigo_BCD` is needed only in the IDLE cycle where `valid` is sampled. Later changes have no effect.
- Reset, any state and mid-conversion: next state IDLE; counter, accumulator, sign and `digit_err` cleared; any partial result discarded and no `done` issued.

## Timing
- Reset values: `bin`=0x0000, `busy`=0, `done`=0, `error`=0.
- Edge E0: `valid` sampled high in IDLE. `busy` is high after E0.
- Edges E1..E20: the 20 shifts.
- Edge E21: FINISH registers `bin`/`error`, sets `done`=1 and `busy`=0.
- Fixed latency: 21 cycles from the `valid` sample to `done`.
- `done` is high exactly one cycle; it falls at E22.
- Back-to-back: `valid` can be accepted at E22 at the earliest (IDLE resumes after E21). Throughput is 1 conversion per 22 cycles.
- `valid` high in the same cycle as `reset`: reset wins and the request is dropped.
- `bin` and `error` change only at a FINISH edge or on reset.

## Test plan
- +12345 (`codigo_BCD`=0x012345) -> `done` 21 cycles after `valid`, `bin`=0x3039, `error`=0; `busy` high for exactly 21 cycles.
- −12345 (0x112345) -> `bin`=0xCFC7. −32768 (0x132768) -> `bin`=0x8000, `error`=0. −0 (0x100000) -> `bin`=0x0000, `error`=0.
- +32768 (0x032768) -> `error`=1, `bin`=0. +99999 (0x099999) -> `error`=1. +32767 (0x032767) -> `bin`=0x7FFF, `error`=0.
- Illegal digit 0x01A345 -> `done` at the normal latency, `error`=1, `bin`=0. The next valid conversion clears `error`.
- Pulse `valid` with 0x000007, then pulse `valid` with 0x000009 at cycle 5 -> a single `done`, `bin`=0x0007. The second request is ignored.
- Assert `reset` at cycle 10 of a conversion -> next cycle `busy`=0, `bin`=0, `error`=0; no `done`. A fresh `valid` with 0x000042 then yields `bin`=0x002A.
